tcdm_master_shim: RTL and testbench
===================================

Name: tcdm_master_shim

Overview:
- Per-master adapter between a core load/store unit and one master port of the radix-2 butterfly TCDM network.
- Request side:
  - Converts the core's valid/ready request into the network's req/gnt request.
  - Splits the byte address into a bank index and a row address.
  - Packs wen/be/row/wdata into the network data payload.
- Response side: the network returns rdata exactly one cycle after gnt and cannot be back-pressured. The shim buffers responses in a small FIFO and issues requests only when a FIFO slot is reserved.

Parameters:
- NumBanks, 32, number of network slave ports; power of 2.
- AddWidth, $clog2(NumBanks), bank index width (network add).
- DataWidth, 32, word width.
- BeWidth, DataWidth/8, byte-enable width.
- ByteOffWidth, $clog2(BeWidth), word-offset bits skipped in the address.
- RowWidth, 10, row address bits within a bank.
- AddrWidth, 32, core byte-address width.
- ReqDataWidth, 1+BeWidth+RowWidth+DataWidth, network payload width.
- RespFifoDepth, 2, response FIFO entries; minimum 1.
- WriteRespOn, 1, writes return a response (must match network setting).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  core request accepted
- req_addr_i  in  AddrWidth  byte address
- req_wen_i  in  1  1=write
- req_be_i  in  BeWidth  byte enables
- req_wdata_i  in  DataWidth  write data
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  core accepts response
- resp_rdata_o  out  DataWidth  read data (0 for writes)
- net_req_o  out  1  network request
- net_gnt_i  in  1  network grant (same cycle)
- net_add_o  out  AddWidth  bank index
- net_wen_o  out  1  write flag
- net_data_o  out  ReqDataWidth  payload {wen, be, row, wdata} MSB..LSB
- net_rdata_i  in  DataWidth  network response data
- net_vld_i  in  1  network response valid (cycle after gnt)

Behaviour:
- Address mapping:
  - net_add_o = req_addr_i[ByteOffWidth +: AddWidth].
  - row = req_addr_i[ByteOffWidth+AddWidth +: RowWidth].
  - Upper address bits are ignored.
- Init flag:
  - init_q resets to 0 and sets to 1 on the first clock edge after rst_ni is released.
  - All network requests are gated by init_q.
- needs_resp = ~req_wen_i | WriteRespOn.
- pend_q (1 bit): set on a handshake (net_req_o & net_gnt_i) with needs_resp; otherwise cleared. At most one response is in flight.
- cnt_q: FIFO occupancy, width $clog2(RespFifoDepth+1).
- Credit check: space = (cnt_q + pend_q) < RespFifoDepth. It is evaluated on registered state only; no combinational path from resp_ready_i to net_req_o.
- Request issue:
  - net_req_o = init_q & req_valid_i & (space | ~needs_resp).
  - req_ready_o = net_req_o & net_gnt_i.
  - Payload passes through combinationally.
  - Core holds its request stable until ready.
- Response path, on net_vld_i:
  - Fall-through: if the FIFO is empty and resp_ready_i=1, the response is presented combinationally (resp_valid_o=1, resp_rdata_o=net_rdata_i) and not stored.
  - Otherwise it is pushed to the FIFO.
  - Write responses carry rdata forced to 0.
- Response output:
  - resp_valid_o = (cnt_q!=0) | net_vld_i.
  - FIFO head takes priority over a new net_vld_i; that net_vld_i is pushed.
- Simultaneous push and pop: cnt_q unchanged, pointers both advance, wrap modulo RespFifoDepth.
- Overflow cannot occur by construction. Sim assertions are required for:
  - push while full;
  - net_vld_i while pend_q=0;
  - pend_q=1 without net_vld_i.
- Throughput: one request per cycle sustained when resp_ready_i=1 and RespFifoDepth>=2. With depth 1, throughput is one request per 2 cycles.
- Reset values (async, mid-operation included):
  - init_q=0, pend_q=0, cnt_q=0, FIFO pointers 0.
  - Therefore net_req_o=0, req_ready_o=0, resp_valid_o=0 (unless net_vld_i is driven).
  - An in-flight response is discarded; the network is reset concurrently.

Test Plan:
- Reset release, req_valid_i=1 addr 0x0000_0084 read: net_req_o=0 in the first cycle after release. Next cycle: net_req_o=1, net_add_o=1, row=1, payload wen=0.
- Back-to-back reads to banks 0..7, gnt always 1, resp_ready_i=1, depth 2: 8 grants in 8 consecutive cycles. resp_valid_o in cycles 2..9 in order, rdata matches; cnt_q stays 0.
- resp_ready_i=0, depth 2, continuous reads: exactly 2 grants, then net_req_o=0. Raising resp_ready_i drains 2 responses in order, then issuing resumes.
- WriteRespOn=0, resp_ready_i=0, FIFO full: writes still granted every cycle, no net_vld_i or resp_valid_o. A read is blocked.
- net_gnt_i=0 for 3 cycles on a write (be=0xF, wdata=0xDEADBEEF): net_req_o stays 1, req_ready_o=0, payload stable. On grant, the response is valid next cycle with rdata=0.
- Assert rst_ni low with 1 FIFO entry and pend_q=1: resp_valid_o=0 and cnt_q=0 immediately. No stale response appears after release.

Source files
------------

// File: rtl/tcdm_master_shim_if.sv
// Signal bundle of one TCDM master shim: core load/store request/response side
// plus the master port of the butterfly network.
interface tcdm_master_shim_if #(
    parameter int unsigned NumBanks  = 32,
    parameter int unsigned DataWidth = 32,
    parameter int unsigned RowWidth  = 10,
    parameter int unsigned AddrWidth = 32
);
    localparam int unsigned AddWidth     = $clog2(NumBanks);
    localparam int unsigned BeWidth      = DataWidth / 8;
    localparam int unsigned ReqDataWidth = 1 + BeWidth + RowWidth + DataWidth;

    // Core request
    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [AddrWidth-1:0]    req_addr_i;
    logic                    req_wen_i;
    logic [BeWidth-1:0]      req_be_i;
    logic [DataWidth-1:0]    req_wdata_i;
    // Core response
    logic                    resp_valid_o;
    logic                    resp_ready_i;
    logic [DataWidth-1:0]    resp_rdata_o;
    // Network master port
    logic                    net_req_o;
    logic                    net_gnt_i;
    logic [AddWidth-1:0]     net_add_o;
    logic                    net_wen_o;
    logic [ReqDataWidth-1:0] net_data_o;
    logic [DataWidth-1:0]    net_rdata_i;
    logic                    net_vld_i;

    // Shim side
    modport master (
        input  req_valid_i, req_addr_i, req_wen_i, req_be_i, req_wdata_i,
        output req_ready_o,
        output resp_valid_o, resp_rdata_o,
        input  resp_ready_i,
        output net_req_o, net_add_o, net_wen_o, net_data_o,
        input  net_gnt_i, net_rdata_i, net_vld_i
    );

    // Environment side (core + network)
    modport slave (
        output req_valid_i, req_addr_i, req_wen_i, req_be_i, req_wdata_i,
        input  req_ready_o,
        input  resp_valid_o, resp_rdata_o,
        output resp_ready_i,
        input  net_req_o, net_add_o, net_wen_o, net_data_o,
        output net_gnt_i, net_rdata_i, net_vld_i
    );
endinterface

// File: rtl/tcdm_master_shim.sv
// Per-master adapter from a core valid/ready LSU port to a TCDM network req/gnt port.
// Requests are issued only against a reserved response-FIFO slot, since responses cannot stall.
module tcdm_master_shim #(
    parameter int unsigned NumBanks      = 32,
    parameter int unsigned DataWidth     = 32,
    parameter int unsigned RowWidth      = 10,
    parameter int unsigned AddrWidth     = 32,
    parameter int unsigned RespFifoDepth = 2,
    parameter bit          WriteRespOn   = 1'b1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    tcdm_master_shim_if.master bus
);
    localparam int unsigned AddWidth     = $clog2(NumBanks);
    localparam int unsigned BeWidth      = DataWidth / 8;
    localparam int unsigned ByteOffWidth = $clog2(BeWidth);
    localparam int unsigned RowLsb       = ByteOffWidth + AddWidth;
    localparam int unsigned RowMsb       = RowLsb + RowWidth;
    localparam int unsigned CntWidth     = $clog2(RespFifoDepth + 1);
    localparam int unsigned UsedWidth    = CntWidth + 1;
    localparam int unsigned PtrWidth     = (RespFifoDepth > 1) ? $clog2(RespFifoDepth) : 1;

    logic                 init_q, init_d;
    logic                 pend_q, pend_d;
    logic                 pend_wen_q, pend_wen_d;
    logic [CntWidth-1:0]  cnt_q, cnt_d;
    logic [PtrWidth-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrWidth-1:0]  rd_ptr_q, rd_ptr_d;
    logic [DataWidth-1:0] mem_q [RespFifoDepth];

    logic                 needs_resp_c;
    logic [UsedWidth-1:0] used_c;
    logic                 space_c;
    logic                 net_req_c;
    logic                 hs_c;
    logic [RowWidth-1:0]  row_c;
    logic                 empty_c;
    logic                 push_c;
    logic                 pop_c;
    logic [DataWidth-1:0] resp_data_c;
    logic                 unused_addr_c;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == PtrWidth'(RespFifoDepth - 1)) ? '0 : p + PtrWidth'(1);
    endfunction

    // Request path: credit check uses registered state only, so resp_ready_i never reaches net_req_o
    always_comb begin
        needs_resp_c = ~bus.req_wen_i | WriteRespOn;
        used_c       = UsedWidth'(cnt_q) + UsedWidth'(pend_q);
        space_c      = used_c < UsedWidth'(RespFifoDepth);
        net_req_c    = init_q & bus.req_valid_i & (space_c | ~needs_resp_c);
        hs_c         = net_req_c & bus.net_gnt_i;
        row_c        = bus.req_addr_i[RowLsb +: RowWidth];

        bus.net_req_o   = net_req_c;
        bus.req_ready_o = hs_c;
        bus.net_add_o   = bus.req_addr_i[ByteOffWidth +: AddWidth];
        bus.net_wen_o   = bus.req_wen_i;
        bus.net_data_o  = {bus.req_wen_i, bus.req_be_i, row_c, bus.req_wdata_i};
    end

    // Byte offset and bits above the row are don't-care for the network
    assign unused_addr_c = ^{bus.req_addr_i[AddrWidth-1:RowMsb], bus.req_addr_i[ByteOffWidth-1:0]};

    // Response path: fall through when empty and the core is ready, else buffer; head has priority
    always_comb begin
        resp_data_c = pend_wen_q ? '0 : bus.net_rdata_i;
        empty_c     = (cnt_q == '0);
        pop_c       = ~empty_c & bus.resp_ready_i;
        push_c      = bus.net_vld_i & ~(empty_c & bus.resp_ready_i);

        bus.resp_valid_o = ~empty_c | bus.net_vld_i;
        bus.resp_rdata_o = empty_c ? resp_data_c : mem_q[rd_ptr_q];
    end

    always_comb begin
        init_d     = 1'b1;
        pend_d     = hs_c & needs_resp_c;
        pend_wen_d = bus.req_wen_i;
        cnt_d      = cnt_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;

        if (push_c) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end
        if (pop_c) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({push_c, pop_c})
            2'b10:   cnt_d = cnt_q + CntWidth'(1);
            2'b01:   cnt_d = cnt_q - CntWidth'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            init_q     <= 1'b0;
            pend_q     <= 1'b0;
            pend_wen_q <= 1'b0;
            cnt_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            init_q     <= init_d;
            pend_q     <= pend_d;
            pend_wen_q <= pend_wen_d;
            cnt_q      <= cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    // Storage needs no reset: occupancy and pointers define validity
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= resp_data_c;
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(push_c && (cnt_q == CntWidth'(RespFifoDepth))))
        else $error("response pushed into full FIFO");

    a_no_stray_vld: assert property (@(posedge clk_i) disable iff (!rst_ni)
        bus.net_vld_i |-> pend_q)
        else $error("net_vld_i without an outstanding request");

    a_vld_follows_pend: assert property (@(posedge clk_i) disable iff (!rst_ni)
        pend_q |-> bus.net_vld_i)
        else $error("outstanding request without net_vld_i");

endmodule

// File: tb/tb_tcdm_master_shim.sv
// Directed bench for tcdm_master_shim: instance A writes respond, instance B writes do not.
module tb_tcdm_master_shim;
    localparam int unsigned NB = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned RW = 10;
    localparam int unsigned AW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    tcdm_master_shim_if #(.NumBanks(NB), .DataWidth(DW), .RowWidth(RW), .AddrWidth(AW)) ifa ();
    tcdm_master_shim_if #(.NumBanks(NB), .DataWidth(DW), .RowWidth(RW), .AddrWidth(AW)) ifb ();

    tcdm_master_shim #(.NumBanks(NB), .DataWidth(DW), .RowWidth(RW), .AddrWidth(AW),
                       .RespFifoDepth(2), .WriteRespOn(1'b1)) dut_a (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifa));

    tcdm_master_shim #(.NumBanks(NB), .DataWidth(DW), .RowWidth(RW), .AddrWidth(AW),
                       .RespFifoDepth(2), .WriteRespOn(1'b0)) dut_b (
        .clk_i(clk), .rst_ni(rst_n), .bus(ifb));

    // Network models: one-cycle response after a grant; read data encodes {row, bank}.
    // Instance A's network answers writes with junk data; instance B's never answers writes.
    logic        hs_a = 1'b0, vld_a = 1'b0, hs_b = 1'b0, vld_b = 1'b0;
    logic [31:0] dat_a = '0, rdat_a = '0, dat_b = '0, rdat_b = '0;

    always @(negedge clk) begin
        hs_a  = rst_n & ifa.net_req_o & ifa.net_gnt_i;
        dat_a = ifa.net_wen_o ? 32'hBAD0_0BAD
              : (32'hA500_0000 | (32'(ifa.net_data_o[DW +: RW]) << 8) | 32'(ifa.net_add_o));
        hs_b  = rst_n & ifb.net_req_o & ifb.net_gnt_i & ~ifb.net_wen_o;
        dat_b = 32'hA500_0000 | (32'(ifb.net_data_o[DW +: RW]) << 8) | 32'(ifb.net_add_o);
    end

    always @(posedge clk) begin
        #1;
        vld_a  = hs_a;
        rdat_a = hs_a ? dat_a : 32'h0;
        vld_b  = hs_b;
        rdat_b = hs_b ? dat_b : 32'h0;
    end

    assign ifa.net_vld_i   = vld_a & rst_n;
    assign ifa.net_rdata_i = rdat_a;
    assign ifb.net_vld_i   = vld_b & rst_n;
    assign ifb.net_rdata_i = rdat_b;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifa.req_valid_i = 1'b1; ifa.req_addr_i = 32'h0000_0084; ifa.req_wen_i = 1'b0;
        ifa.req_be_i = 4'hF; ifa.req_wdata_i = 32'h0; ifa.resp_ready_i = 1'b1; ifa.net_gnt_i = 1'b1;
        ifb.req_valid_i = 1'b0; ifb.req_addr_i = 32'h0; ifb.req_wen_i = 1'b0;
        ifb.req_be_i = 4'hF; ifb.req_wdata_i = 32'h0; ifb.resp_ready_i = 1'b1; ifb.net_gnt_i = 1'b1;
        repeat (2) next_cycle();
        @(negedge clk);
        checks++; if (ifa.net_req_o !== 1'b0) begin errors++; $display("FAIL rst_net_req got %b exp 0", ifa.net_req_o); end
        checks++; if (ifa.req_ready_o !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b exp 0", ifa.req_ready_o); end
        checks++; if (ifa.resp_valid_o !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", ifa.resp_valid_o); end
        next_cycle();
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (ifa.net_req_o !== 1'b0) begin errors++; $display("FAIL init_gate got %b exp 0", ifa.net_req_o); end
        @(negedge clk);
        checks++; if (ifa.net_req_o !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", ifa.net_req_o); end
        checks++; if (ifa.net_add_o !== 5'd1) begin errors++; $display("FAIL first_add got %0d exp 1", ifa.net_add_o); end
        checks++; if (ifa.net_data_o[DW +: RW] !== 10'd1) begin errors++; $display("FAIL first_row got %0d exp 1", ifa.net_data_o[DW +: RW]); end
        checks++; if (ifa.net_data_o[46] !== 1'b0) begin errors++; $display("FAIL first_wen got %b exp 0", ifa.net_data_o[46]); end
        checks++; if (ifa.req_ready_o !== 1'b1) begin errors++; $display("FAIL first_ready got %b exp 1", ifa.req_ready_o); end
        next_cycle();
        ifa.req_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (ifa.resp_valid_o !== 1'b1) begin errors++; $display("FAIL first_resp_valid got %b exp 1", ifa.resp_valid_o); end
        checks++; if (ifa.resp_rdata_o !== 32'hA500_0101) begin errors++; $display("FAIL first_rdata got %h exp a5000101", ifa.resp_rdata_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (ifa.resp_valid_o !== 1'b0) begin errors++; $display("FAIL first_idle got %b exp 0", ifa.resp_valid_o); end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_rd;
        ifa.req_wen_i = 1'b0; ifa.resp_ready_i = 1'b1; ifa.net_gnt_i = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                ifa.req_valid_i = 1'b1;
                ifa.req_addr_i  = 32'(i) << 2;
            end else begin
                ifa.req_valid_i = 1'b0;
            end
            @(negedge clk);
            if (i < 8) begin
                checks++; if (ifa.req_ready_o !== 1'b1) begin errors++; $display("FAIL b2b_grant%0d got %b exp 1", i, ifa.req_ready_o); end
            end
            if (i > 0) begin
                exp_rd = 32'hA500_0000 | 32'(i - 1);
                checks++; if (ifa.resp_valid_o !== 1'b1 || ifa.resp_rdata_o !== exp_rd) begin
                    errors++; $display("FAIL b2b_resp%0d got %b/%h exp 1/%h", i - 1, ifa.resp_valid_o, ifa.resp_rdata_o, exp_rd);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        checks++; if (ifa.resp_valid_o !== 1'b0) begin errors++; $display("FAIL b2b_fifo_empty got %b exp 0", ifa.resp_valid_o); end
        next_cycle();
    endtask

    task automatic test_backpressure();
        logic exp_gnt [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
        int unsigned b = 3;
        ifa.resp_ready_i = 1'b0; ifa.req_wen_i = 1'b0; ifa.net_gnt_i = 1'b1;
        ifa.req_valid_i = 1'b1; ifa.req_addr_i = 32'(b) << 2;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (ifa.req_ready_o !== exp_gnt[c]) begin errors++; $display("FAIL bp_grant%0d got %b exp %b", c, ifa.req_ready_o, exp_gnt[c]); end
            if (c >= 1) begin
                checks++; if (ifa.resp_valid_o !== 1'b1) begin errors++; $display("FAIL bp_valid%0d got %b exp 1", c, ifa.resp_valid_o); end
            end
            if (c == 3) begin
                checks++; if (ifa.resp_rdata_o !== 32'hA500_0003) begin errors++; $display("FAIL bp_head got %h exp a5000003", ifa.resp_rdata_o); end
            end
            next_cycle();
            if (exp_gnt[c]) begin
                b++;
                ifa.req_addr_i = 32'(b) << 2;
            end
        end
        ifa.resp_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (ifa.resp_rdata_o !== 32'hA500_0003) begin errors++; $display("FAIL bp_drain0 got %h exp a5000003", ifa.resp_rdata_o); end
        checks++; if (ifa.net_req_o !== 1'b0) begin errors++; $display("FAIL bp_still_blocked got %b exp 0", ifa.net_req_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (ifa.resp_rdata_o !== 32'hA500_0004) begin errors++; $display("FAIL bp_drain1 got %h exp a5000004", ifa.resp_rdata_o); end
        checks++; if (ifa.req_ready_o !== 1'b1) begin errors++; $display("FAIL bp_resume got %b exp 1", ifa.req_ready_o); end
        next_cycle();
        ifa.req_valid_i = 1'b0;
        @(negedge clk);
        checks++; if (ifa.resp_valid_o !== 1'b1 || ifa.resp_rdata_o !== 32'hA500_0005) begin
            errors++; $display("FAIL bp_resumed_resp got %b/%h exp 1/a5000005", ifa.resp_valid_o, ifa.resp_rdata_o);
        end
        next_cycle();
        @(negedge clk);
        checks++; if (ifa.resp_valid_o !== 1'b0) begin errors++; $display("FAIL bp_idle got %b exp 0", ifa.resp_valid_o); end
        next_cycle();
    endtask

    task automatic test_no_write_resp();
        ifb.resp_ready_i = 1'b0; ifb.net_gnt_i = 1'b1; ifb.req_valid_i = 1'b1;
        ifb.req_wen_i = 1'b0; ifb.req_addr_i = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checks++; if (ifb.req_ready_o !== 1'b1) begin errors++; $display("FAIL nwr_grant%0d got %b exp 1", c, ifb.req_ready_o); end
            if (c >= 3) begin
                checks++; if (ifb.net_vld_i !== 1'b0) begin errors++; $display("FAIL nwr_no_vld%0d got %b exp 0", c, ifb.net_vld_i); end
                checks++; if (ifb.resp_rdata_o !== 32'hA500_0000) begin errors++; $display("FAIL nwr_head%0d got %h exp a5000000", c, ifb.resp_rdata_o); end
            end
            next_cycle();
            ifb.req_addr_i  = 32'(c + 1) << 2;
            ifb.req_wen_i   = (c >= 1) && (c < 4);
            ifb.req_be_i    = 4'hF;
            ifb.req_wdata_i = 32'h1234_5678;
        end
        @(negedge clk);
        checks++; if (ifb.net_req_o !== 1'b0) begin errors++; $display("FAIL nwr_read_blocked got %b exp 0", ifb.net_req_o); end
        next_cycle();
        ifb.req_valid_i = 1'b0; ifb.req_wen_i = 1'b0; ifb.resp_ready_i = 1'b1;
        @(negedge clk);
        checks++; if (ifb.resp_rdata_o !== 32'hA500_0000) begin errors++; $display("FAIL nwr_drain0 got %h exp a5000000", ifb.resp_rdata_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (ifb.resp_rdata_o !== 32'hA500_0001) begin errors++; $display("FAIL nwr_drain1 got %h exp a5000001", ifb.resp_rdata_o); end
        next_cycle();
        @(negedge clk);
        checks++; if (ifb.resp_valid_o !== 1'b0) begin errors++; $display("FAIL nwr_idle got %b exp 0", ifb.resp_valid_o); end
        next_cycle();
    endtask

    task automatic test_gnt_stall();
        logic [46:0] exp_pl = {1'b1, 4'hF, 10'd0, 32'hDEAD_BEEF};
        ifa.resp_ready_i = 1'b1; ifa.req_valid_i = 1'b1; ifa.req_wen_i = 1'b1;
        ifa.req_addr_i = 32'h10; ifa.req_be_i = 4'hF; ifa.req_wdata_i = 32'hDEAD_BEEF;
        for (int c = 0; c < 4; c++) begin
            ifa.net_gnt_i = (c == 3);
            @(negedge clk);
            checks++; if (ifa.net_req_o !== 1'b1) begin errors++; $display("FAIL stall_req%0d got %b exp 1", c, ifa.net_req_o); end
            checks++; if (ifa.req_ready_o !== (c == 3)) begin errors++; $display("FAIL stall_ready%0d got %b exp %b", c, ifa.req_ready_o, c == 3); end
            checks++; if (ifa.net_data_o !== exp_pl) begin errors++; $display("FAIL stall_payload%0d got %h exp %h", c, ifa.net_data_o, exp_pl); end
            next_cycle();
        end
        ifa.req_valid_i = 1'b0; ifa.req_wen_i = 1'b0;
        @(negedge clk);
        checks++; if (ifa.resp_valid_o !== 1'b1 || ifa.resp_rdata_o !== 32'h0) begin
            errors++; $display("FAIL stall_wr_resp got %b/%h exp 1/00000000", ifa.resp_valid_o, ifa.resp_rdata_o);
        end
        next_cycle();
        @(negedge clk);
        checks++; if (ifa.resp_valid_o !== 1'b0) begin errors++; $display("FAIL stall_idle got %b exp 0", ifa.resp_valid_o); end
        next_cycle();
    endtask

    task automatic test_reset_mid();
        ifa.resp_ready_i = 1'b0; ifa.net_gnt_i = 1'b1; ifa.req_valid_i = 1'b1;
        ifa.req_wen_i = 1'b0; ifa.req_addr_i = 32'h18;
        @(negedge clk);
        checks++; if (ifa.req_ready_o !== 1'b1) begin errors++; $display("FAIL mid_grant0 got %b exp 1", ifa.req_ready_o); end
        next_cycle();
        ifa.req_addr_i = 32'h1C;
        @(negedge clk);
        checks++; if (ifa.req_ready_o !== 1'b1) begin errors++; $display("FAIL mid_grant1 got %b exp 1", ifa.req_ready_o); end
        next_cycle();
        ifa.req_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++; if (ifa.resp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_valid got %b exp 0", ifa.resp_valid_o); end
        checks++; if (dut_a.cnt_q !== 2'd0) begin errors++; $display("FAIL mid_rst_cnt got %0d exp 0", dut_a.cnt_q); end
        next_cycle();
        rst_n = 1'b1;
        ifa.resp_ready_i = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++; if (ifa.resp_valid_o !== 1'b0) begin errors++; $display("FAIL mid_stale%0d got %b exp 0", c, ifa.resp_valid_o); end
            next_cycle();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_no_write_resp();
        test_gnt_stall();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
